// File: rtl/mtx_tx_ctrl.sv
// Free-running frame transmitter: a SYNC pulse on fp_gpio_out[0], then NSYMB tone symbols on itx/qtx.
// Optional build macro MTX_CTRL_GPIO_DBG_EN exposes the state code and tx_trig on fp_gpio_out[3:1].
module mtx_tx_ctrl #(
  parameter int unsigned             DATA_WIDTH  = 16,
  parameter int unsigned             PHASE_WIDTH = 24,
  parameter int unsigned             NSYMB_WIDTH = 16,
  parameter int unsigned             NSYMB       = 64,
  parameter int unsigned             NSIG        = 2048,
  parameter int unsigned             SYNC_LEN    = 32678,
  parameter logic [PHASE_WIDTH-1:0]  PH_BASE     = 24'h010000,
  parameter logic [PHASE_WIDTH-1:0]  PH_STEP     = 24'h000800
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [DATA_WIDTH-1:0]  itx,
  output logic [DATA_WIDTH-1:0]  qtx,
  output logic [11:0]            fp_gpio_out,
  output logic [11:0]            fp_gpio_ddr,
  input  logic [11:0]            fp_gpio_in,
  output logic                   tx_trig,
  output logic                   tx_valid,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic [PHASE_WIDTH-1:0] sigN,
  output logic [PHASE_WIDTH-1:0] ph,
  output logic [DATA_WIDTH-1:0]  sin,
  output logic [DATA_WIDTH-1:0]  cos
);

  localparam int unsigned SYNC_CW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int unsigned ROM_DW  = 15;
  localparam int unsigned ROM_N   = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_CW-1:0]     r_sync_cnt;
  logic [PHASE_WIDTH-1:0] r_sig;
  logic [NSYMB_WIDTH-1:0] r_symb;
  logic [PHASE_WIDTH-1:0] r_ph;
  logic [PHASE_WIDTH-1:0] r_ph_inc;
  logic                   r_trig;
  logic                   r_gpio0;

  logic [ROM_DW-1:0]      r_rom_s;
  logic [ROM_DW-1:0]      r_rom_c;
  logic                   r_neg_s;
  logic                   r_neg_c;
  logic                   r_tx_d1;
  logic                   r_tx_valid;
  logic [DATA_WIDTH-1:0]  r_sin;
  logic [DATA_WIDTH-1:0]  r_cos;
  logic [DATA_WIDTH-1:0]  r_itx;
  logic [DATA_WIDTH-1:0]  r_qtx;

  logic [9:0]             w_pa;
  logic [7:0]             w_addr_s;
  logic [7:0]             w_addr_c;
  logic [ROM_DW-1:0]      w_rom [ROM_N];
  logic [DATA_WIDTH-1:0]  w_sin_nxt;
  logic [DATA_WIDTH-1:0]  w_cos_nxt;
  logic                   w_unused_gpio_in;

  // Quarter-wave entry k = round(32767*sin(2*pi*(k+0.5)/1024)), evaluated at elaboration.
  function automatic logic [ROM_DW-1:0] rom_entry(input int k);
    real a;
    a = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0);
    return ROM_DW'($rtoi(a + 0.5));
  endfunction

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    assign w_rom[k] = rom_entry(k);
  end

  // Frame sequencer; SYNC holds counters at zero, TX entries preload the next sample's outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_sig      <= '0;
      r_symb     <= '0;
      r_ph       <= '0;
      r_ph_inc   <= '0;
      r_trig     <= 1'b0;
      r_gpio0    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_SYNC;
          r_sync_cnt <= '0;
          r_gpio0    <= 1'b1;
        end
        ST_SYNC: begin
          if (r_sync_cnt == SYNC_CW'(SYNC_LEN - 1)) begin
            r_state  <= ST_TX;
            r_trig   <= 1'b1;
            r_ph_inc <= PH_BASE;
            r_gpio0  <= 1'b0;
          end else begin
            r_sync_cnt <= r_sync_cnt + SYNC_CW'(1);
          end
        end
        ST_TX: begin
          if (r_sig == PHASE_WIDTH'(NSIG - 1)) begin
            r_sig <= '0;
            r_ph  <= '0;
            if (r_symb == NSYMB_WIDTH'(NSYMB - 1)) begin
              r_state    <= ST_SYNC;
              r_symb     <= '0;
              r_sync_cnt <= '0;
              r_trig     <= 1'b0;
              r_gpio0    <= 1'b1;
            end else begin
              r_symb   <= r_symb + NSYMB_WIDTH'(1);
              r_ph_inc <= r_ph_inc + PH_STEP;
              r_trig   <= 1'b1;
            end
          end else begin
            r_sig  <= r_sig + PHASE_WIDTH'(1);
            r_ph   <= r_ph + r_ph_inc;
            r_trig <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_gpio0 <= 1'b0;
        end
      endcase
    end
  end

  // Quadrant folding: odd quadrants read the ROM mirrored, sign follows the quadrant.
  assign w_pa     = r_ph[PHASE_WIDTH-1 -: 10];
  assign w_addr_s = w_pa[8] ? ~w_pa[7:0] : w_pa[7:0];
  assign w_addr_c = w_pa[8] ? w_pa[7:0] : ~w_pa[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rom_s <= '0;
      r_rom_c <= '0;
      r_neg_s <= 1'b0;
      r_neg_c <= 1'b0;
      r_tx_d1 <= 1'b0;
    end else begin
      r_rom_s <= w_rom[w_addr_s];
      r_rom_c <= w_rom[w_addr_c];
      r_neg_s <= w_pa[9];
      r_neg_c <= w_pa[9] ^ w_pa[8];
      r_tx_d1 <= (r_state == ST_TX);
    end
  end

  assign w_sin_nxt = r_neg_s ? -DATA_WIDTH'(r_rom_s) : DATA_WIDTH'(r_rom_s);
  assign w_cos_nxt = r_neg_c ? -DATA_WIDTH'(r_rom_c) : DATA_WIDTH'(r_rom_c);

  // Second stage: signed samples, gated I/Q and the matching valid flag land together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sin      <= '0;
      r_cos      <= '0;
      r_itx      <= '0;
      r_qtx      <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_sin      <= w_sin_nxt;
      r_cos      <= w_cos_nxt;
      r_itx      <= r_tx_d1 ? w_cos_nxt : '0;
      r_qtx      <= r_tx_d1 ? w_sin_nxt : '0;
      r_tx_valid <= r_tx_d1;
    end
  end

  assign w_unused_gpio_in = ^fp_gpio_in;

  assign itx      = r_itx;
  assign qtx      = r_qtx;
  assign sin      = r_sin;
  assign cos      = r_cos;
  assign tx_valid = r_tx_valid;
  assign tx_trig  = r_trig;
  assign symbN    = r_symb;
  assign sigN     = r_sig;
  assign ph       = r_ph;

`ifdef MTX_CTRL_GPIO_DBG_EN
  assign fp_gpio_out = {8'h00, r_trig, r_state, r_gpio0};
  assign fp_gpio_ddr = 12'h00F;
`else
  assign fp_gpio_out = {11'h000, r_gpio0};
  assign fp_gpio_ddr = 12'h001;
`endif

endmodule

// File: tb/tb_mtx_tx_ctrl.sv
// Bench for mtx_tx_ctrl: two small-frame instances checked every cycle against a time-indexed frame model.
module tb_mtx_tx_ctrl;

  localparam int NSIG     = 4;
  localparam int NSYMB    = 3;
  localparam int SYNC_LEN = 5;
  localparam int FRAME    = SYNC_LEN + NSYMB * NSIG;
  localparam logic [23:0] A_BASE = 24'h0A3D71;
  localparam logic [23:0] A_STEP = 24'h123457;
  localparam logic [23:0] B_BASE = 24'h400000;
  localparam logic [23:0] B_STEP = 24'h000000;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] fp_gpio_in = '0;

  logic [15:0] a_itx, a_qtx, a_sin, a_cos, a_symb;
  logic [23:0] a_sig, a_ph;
  logic [11:0] a_gout, a_gddr;
  logic        a_trig, a_vld;
  logic [15:0] b_itx, b_qtx, b_sin, b_cos, b_symb;
  logic [23:0] b_sig, b_ph;
  logic [11:0] b_gout, b_gddr;
  logic        b_trig, b_vld;

  int t;
  bit in_rst;
  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  mtx_tx_ctrl #(.NSYMB(NSYMB), .NSIG(NSIG), .SYNC_LEN(SYNC_LEN),
                .PH_BASE(A_BASE), .PH_STEP(A_STEP)) u_dut_a (
    .clk(clk), .reset(reset), .itx(a_itx), .qtx(a_qtx),
    .fp_gpio_out(a_gout), .fp_gpio_ddr(a_gddr), .fp_gpio_in(fp_gpio_in),
    .tx_trig(a_trig), .tx_valid(a_vld), .symbN(a_symb), .sigN(a_sig),
    .ph(a_ph), .sin(a_sin), .cos(a_cos)
  );

  mtx_tx_ctrl #(.NSYMB(NSYMB), .NSIG(NSIG), .SYNC_LEN(SYNC_LEN),
                .PH_BASE(B_BASE), .PH_STEP(B_STEP)) u_dut_b (
    .clk(clk), .reset(reset), .itx(b_itx), .qtx(b_qtx),
    .fp_gpio_out(b_gout), .fp_gpio_ddr(b_gddr), .fp_gpio_in(fp_gpio_in),
    .tx_trig(b_trig), .tx_valid(b_vld), .symbN(b_symb), .sigN(b_sig),
    .ph(b_ph), .sin(b_sin), .cos(b_cos)
  );

  // Reference frame timeline: t=0 is the IDLE cycle at reset release, then SYNC, TX, SYNC, ...
  function automatic int st_at(input int tt);
    if (tt <= 0) return 0;
    return (((tt - 1) % FRAME) < SYNC_LEN) ? 1 : 2;
  endfunction

  function automatic int tx_pos(input int tt);
    return ((tt - 1) % FRAME) - SYNC_LEN;
  endfunction

  function automatic int sig_at(input int tt);
    if (st_at(tt) != 2) return 0;
    return tx_pos(tt) % NSIG;
  endfunction

  function automatic int symb_at(input int tt);
    if (st_at(tt) != 2) return 0;
    return tx_pos(tt) / NSIG;
  endfunction

  function automatic logic [23:0] ph_at(input int tt, input logic [23:0] base, input logic [23:0] step);
    logic [63:0] inc;
    logic [63:0] acc;
    if (st_at(tt) != 2) return '0;
    inc = 64'(base) + 64'(symb_at(tt)) * 64'(step);
    acc = 64'(sig_at(tt)) * inc;
    return acc[23:0];
  endfunction

  function automatic int ref_wave(input logic [23:0] p, input bit want_cos);
    real ang;
    real v;
    ang = 2.0 * PI * (real'(int'(p[23:14])) + 0.5) / 1024.0;
    v = 32767.0 * (want_cos ? $cos(ang) : $sin(ang));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_dut(input string id, input logic [23:0] base, input logic [23:0] step,
                           input logic [15:0] itx_o, input logic [15:0] qtx_o,
                           input logic [11:0] gout, input logic [11:0] gddr,
                           input logic trig, input logic vld, input logic [15:0] symb_o,
                           input logic [23:0] sig_o, input logic [23:0] ph_o,
                           input logic [15:0] sin_o, input logic [15:0] cos_o);
    int st, sg, sb, mag;
    logic [23:0] e_ph;
    logic        e_trig, e_vld;
    logic [15:0] e_sin, e_cos;
    logic [11:0] e_gpio, e_ddr;
    real         r;
    st = 0; sg = 0; sb = 0; e_ph = '0; e_vld = 1'b0; e_sin = '0; e_cos = '0;
    if (!in_rst) begin
      st   = st_at(t);
      sg   = sig_at(t);
      sb   = symb_at(t);
      e_ph = ph_at(t, base, step);
      if (t >= 2) begin
        e_vld = (st_at(t - 2) == 2);
        e_sin = 16'(ref_wave(ph_at(t - 2, base, step), 1'b0));
        e_cos = 16'(ref_wave(ph_at(t - 2, base, step), 1'b1));
      end
    end
    e_trig = (st == 2) && (sg == 0);
`ifdef MTX_CTRL_GPIO_DBG_EN
    e_gpio = {8'h00, e_trig, 2'(st), st == 1};
    e_ddr  = 12'h00F;
`else
    e_gpio = {11'h000, st == 1};
    e_ddr  = 12'h001;
`endif
    chk({id, ".gpio_out"}, 32'(gout), 32'(e_gpio));
    chk({id, ".gpio_ddr"}, 32'(gddr), 32'(e_ddr));
    chk({id, ".sigN"}, 32'(sig_o), 32'(sg));
    chk({id, ".symbN"}, 32'(symb_o), 32'(sb));
    chk({id, ".ph"}, 32'(ph_o), 32'(e_ph));
    chk({id, ".tx_trig"}, 32'(trig), 32'(e_trig));
    chk({id, ".tx_valid"}, 32'(vld), 32'(e_vld));
    chk({id, ".sin"}, 32'(sin_o), 32'(e_sin));
    chk({id, ".cos"}, 32'(cos_o), 32'(e_cos));
    chk({id, ".itx"}, 32'(itx_o), 32'(e_vld ? e_cos : 16'h0000));
    chk({id, ".qtx"}, 32'(qtx_o), 32'(e_vld ? e_sin : 16'h0000));
    if (e_vld) begin
      r = $sqrt(real'(int'($signed(itx_o))) * real'(int'($signed(itx_o))) +
                real'(int'($signed(qtx_o))) * real'(int'($signed(qtx_o))));
      mag = int'($floor(r));
      chk({id, ".magnitude_in_range"}, 32'(mag >= 32000 && mag <= 32767), 32'd1);
    end
  endtask

  task automatic check_all();
    check_dut("A", A_BASE, A_STEP, a_itx, a_qtx, a_gout, a_gddr, a_trig, a_vld,
              a_symb, a_sig, a_ph, a_sin, a_cos);
    check_dut("B", B_BASE, B_STEP, b_itx, b_qtx, b_gout, b_gddr, b_trig, b_vld,
              b_symb, b_sig, b_ph, b_sin, b_cos);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!in_rst) t++;
    fp_gpio_in = 12'($urandom);
    check_all();
  endtask

  task automatic release_rst();
    reset  = 1'b1;
    in_rst = 1'b0;
    t      = 0;
    check_all();
  endtask

  // Assert reset between clock edges and check the clear before the next edge arrives.
  task automatic async_rst();
    #2 reset = 1'b0;
    in_rst = 1'b1;
    #1 check_all();
    repeat ($urandom_range(1, 3)) step();
    release_rst();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    t      = 0;
    in_rst = 1'b1;
    reset  = 1'b0;
    repeat (3) step();
    release_rst();
    repeat (2 * FRAME + 3 + $urandom_range(0, 8)) step();

    repeat ($urandom_range(0, FRAME - 1)) step();
    while (st_at(t) != 2) step();
    async_rst();
    repeat (SYNC_LEN + 2) step();

    async_rst();
    repeat ($urandom_range(1, SYNC_LEN - 1)) step();
    async_rst();

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(3, 2 * FRAME)) step();
      async_rst();
    end
    repeat (2 * FRAME + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

endmodule
